memory_port_arbiter: RTL and testbench

//   Shares the coprocessor's single-port block memory between the p block processors.

---
 rtl/memory_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one single-port block memory among p processors.
// Each grant lasts until the holder drops its request or hits max_burst while others wait.

module memory_port_arbiter_lane #(
    parameter int data_width      = 32,
    parameter int memory_size_log = 10
) (
    input  logic                       grant,
    input  logic                       req,
    input  logic                       write_en,
    input  logic [memory_size_log-1:0] addr,
    input  logic [data_width-1:0]      write_data,
    output logic [memory_size_log-1:0] addr_gated,
    output logic [data_width-1:0]      data_gated,
    output logic                       write_gated,
    output logic                       read_access
);
    // Non-granted lanes contribute zeros so the top can OR all lanes together.
    assign addr_gated  = grant ? addr : '0;
    assign data_gated  = grant ? write_data : '0;
    assign write_gated = grant & req & write_en;
    assign read_access = grant & req & ~write_en;
endmodule

module memory_port_arbiter #(
    parameter int p               = 4,
    parameter int data_width      = 32,
    parameter int memory_size_log = 10,
    parameter int max_burst       = 16
) (
    input  logic                            i_Clock,
    input  logic                            i_Reset,
    input  logic [p-1:0]                    i_Req,
    input  logic [p-1:0]                    i_Write_En,
    input  logic [p*memory_size_log-1:0]    i_Addr,
    input  logic [p*data_width-1:0]         i_Write_Data,
    input  logic [data_width-1:0]           i_Mem_Read_Data,
    output logic [p-1:0]                    o_Grant,
    output logic [memory_size_log-1:0]      o_Mem_Addr,
    output logic [data_width-1:0]           o_Mem_Write_Data,
    output logic                            o_Mem_Write_En,
    output logic [data_width-1:0]           o_Read_Data,
    output logic [p-1:0]                    o_Read_Valid
);
    localparam int IDX_W = (p > 1) ? $clog2(p) : 1;
    localparam int CNT_W = $clog2(max_burst);

    typedef enum logic {s_Idle, s_Grant} state_t;

    state_t             r_State, n_State;
    logic [p-1:0]       n_Grant;
    logic [IDX_W-1:0]   r_Last, n_Last, pick_idx;
    logic [CNT_W-1:0]   r_Count, n_Count;
    logic               pick_found, access, others_waiting;

    logic [p-1:0]                 lane_write, lane_read;
    logic [memory_size_log-1:0]   lane_addr [p];
    logic [data_width-1:0]        lane_data [p];

    for (genvar g = 0; g < p; g++) begin : g_lane
        memory_port_arbiter_lane #(
            .data_width      (data_width),
            .memory_size_log (memory_size_log)
        ) u_lane (
            .grant       (o_Grant[g]),
            .req         (i_Req[g]),
            .write_en    (i_Write_En[g]),
            .addr        (i_Addr[g*memory_size_log +: memory_size_log]),
            .write_data  (i_Write_Data[g*data_width +: data_width]),
            .addr_gated  (lane_addr[g]),
            .data_gated  (lane_data[g]),
            .write_gated (lane_write[g]),
            .read_access (lane_read[g])
        );
    end

    always_comb begin
        o_Mem_Addr       = '0;
        o_Mem_Write_Data = '0;
        for (int k = 0; k < p; k++) begin
            o_Mem_Addr       = o_Mem_Addr | lane_addr[k];
            o_Mem_Write_Data = o_Mem_Write_Data | lane_data[k];
        end
    end

    assign o_Mem_Write_En = |lane_write;
    assign o_Read_Data    = i_Mem_Read_Data;
    assign access         = |(o_Grant & i_Req);
    assign others_waiting = |(i_Req & ~o_Grant);

    // First requester after the last-granted one, wrapping around.
    always_comb begin
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = r_Last;
        for (int i = 1; i <= p; i++) begin
            if (!pick_found) begin
                j = (int'(r_Last) + i) % p;
                if (i_Req[j]) begin
                    pick_found = 1'b1;
                    pick_idx   = IDX_W'(j);
                end
            end
        end
    end

    always_comb begin
        n_State = r_State;
        n_Grant = o_Grant;
        n_Last  = r_Last;
        n_Count = r_Count;
        case (r_State)
            s_Idle: begin
                if (pick_found) begin
                    n_Grant           = '0;
                    n_Grant[pick_idx] = 1'b1;
                    n_Last            = pick_idx;
                    n_Count           = '0;
                    n_State           = s_Grant;
                end
            end
            s_Grant: begin
                if (!access) begin
                    n_Grant = '0;
                    n_State = s_Idle;
                end else if (r_Count == CNT_W'(max_burst - 1)) begin
                    // Burst cap only forces a release when someone else is waiting.
                    n_Count = '0;
                    if (others_waiting) begin
                        n_Grant = '0;
                        n_State = s_Idle;
                    end
                end else begin
                    n_Count = r_Count + CNT_W'(1);
                end
            end
            default: begin
                n_Grant = '0;
                n_State = s_Idle;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_State      <= s_Idle;
            o_Grant      <= '0;
            r_Last       <= IDX_W'(p - 1);
            r_Count      <= '0;
            o_Read_Valid <= '0;
        end else begin
            r_State      <= n_State;
            o_Grant      <= n_Grant;
            r_Last       <= n_Last;
            r_Count      <= n_Count;
            o_Read_Valid <= lane_read;
        end
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: inputs change 1ns after the rising edge,
// outputs are checked 1ns later, well clear of the next edge.

module tb_memory_port_arbiter;
    localparam int P  = 4;
    localparam int DW = 32;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [P-1:0]    req, we;
    logic [P*AW-1:0] addr;
    logic [P*DW-1:0] wdata;
    logic [DW-1:0]   mem_rdata;
    logic [P-1:0]    grant, rvalid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, rdata;
    logic            mem_we;

    int n_cmp = 0;
    int n_err = 0;

    memory_port_arbiter #(.p(P), .data_width(DW), .memory_size_log(AW), .max_burst(16)) dut (
        .i_Clock          (clk),
        .i_Reset          (rst_n),
        .i_Req            (req),
        .i_Write_En       (we),
        .i_Addr           (addr),
        .i_Write_Data     (wdata),
        .i_Mem_Read_Data  (mem_rdata),
        .o_Grant          (grant),
        .o_Mem_Addr       (mem_addr),
        .o_Mem_Write_Data (mem_wdata),
        .o_Mem_Write_En   (mem_we),
        .o_Read_Data      (rdata),
        .o_Read_Valid     (rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [P-1:0] oh(input int k);
        logic [P-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        we        = '0;
        addr      = '0;
        wdata     = '0;
        mem_rdata = 32'h1234_5678;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", mem_we, 0);
        chk("rdata_bcast", rdata, 32'h1234_5678);
        step();
        rst_n = 1'b1;

        // 1: single reader, addresses 5,6,7
        req = 4'b0001;
        addr[0 +: AW] = 10'd5;
        #1;
        chk("t1_idle_grant", grant, 0);
        step();
        chk("t1_grant", grant, 4'b0001);
        chk("t1_addr5", mem_addr, 5);
        chk("t1_rv_c1", rvalid, 0);
        step();
        addr[0 +: AW] = 10'd6;
        #1;
        chk("t1_addr6", mem_addr, 6);
        chk("t1_rv_c2", rvalid, 4'b0001);
        step();
        addr[0 +: AW] = 10'd7;
        #1;
        chk("t1_addr7", mem_addr, 7);
        chk("t1_rv_c3", rvalid, 4'b0001);
        step();
        req = '0;
        #1;
        chk("t1_rv_c4", rvalid, 4'b0001);
        chk("t1_grant_held", grant, 4'b0001);
        step();
        chk("t1_released", grant, 0);
        chk("t1_rv_c5", rvalid, 0);

        // 2: four requesters, two accesses each, round-robin with one bubble
        do_reset();
        req = 4'b1111;
        #1;
        chk("t2_idle", grant, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_grant%0d", i), grant, oh(i % P));
            step();
            step();
            req[i % P] = 1'b0;
            #1;
            chk($sformatf("t2_hold%0d", i), grant, oh(i % P));
            step();
            req[i % P] = 1'b1;
            #1;
            chk($sformatf("t2_bubble%0d", i), grant, 0);
            step();
        end

        // 3: burst cap with a waiter, no cap when alone
        do_reset();
        req = 4'b0100;
        addr[2*AW +: AW] = 10'h2AA;
        step();
        for (int c = 1; c <= 16; c++) begin
            if (c == 5) req[0] = 1'b1;
            #1;
            chk($sformatf("t3_burst_c%0d", c), grant, 4'b0100);
            step();
        end
        chk("t3_bubble", grant, 0);
        step();
        chk("t3_p0_grant", grant, 4'b0001);
        step();
        req[0] = 1'b0;
        #1;
        chk("t3_p0_hold", grant, 4'b0001);
        step();
        chk("t3_bubble2", grant, 0);
        step();
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("t3_alone_c%0d", c), grant, 4'b0100);
            step();
        end
        chk("t3_alone_addr", mem_addr, 10'h2AA);

        // 4: proc 1 writes, proc 3 toggles write enable without a grant
        do_reset();
        addr[1*AW +: AW]  = 10'h3FF;
        wdata[1*DW +: DW] = 32'hDEAD_BEEF;
        addr[3*AW +: AW]  = 10'h155;
        wdata[3*DW +: DW] = 32'hCAFE_F00D;
        req = 4'b0010;
        we  = 4'b1010;
        #1;
        chk("t4_idle_we", mem_we, 0);
        chk("t4_idle_addr", mem_addr, 0);
        chk("t4_idle_data", mem_wdata, 0);
        step();
        chk("t4_we", mem_we, 1);
        chk("t4_addr", mem_addr, 10'h3FF);
        chk("t4_data", mem_wdata, 32'hDEAD_BEEF);
        step();
        req = '0;
        we[3] = 1'b0;
        #1;
        chk("t4_we_drop", mem_we, 0);
        chk("t4_no_rv", rvalid, 0);
        step();
        we[3] = 1'b1;
        #1;
        chk("t4_released", grant, 0);
        chk("t4_p3_ignored", mem_we, 0);
        chk("t4_p3_addr", mem_addr, 0);

        // 5: asynchronous reset mid-burst with a read in flight
        do_reset();
        addr[2*AW +: AW] = 10'h011;
        req = 4'b0100;
        we  = '0;
        step();
        chk("t5_grant", grant, 4'b0100);
        step();
        we[2] = 1'b1;
        #1;
        chk("t5_rv", rvalid, 4'b0100);
        chk("t5_we_pre", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_rv", rvalid, 0);
        chk("t5_rst_we", mem_we, 0);
        req = 4'b1111;
        we  = '0;
        step();
        rst_n = 1'b1;
        #1;
        chk("t5_post_idle", grant, 0);
        step();
        chk("t5_p0_first", grant, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
